// File: rtl/wb_prog_loader.sv
// Wishbone slave that downloads the jacaranda-8 instruction memory and holds the CPU
// in reset while loading. It also tracks a byte count and an additive checksum.
module wb_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  imem_addr,
    output logic [7:0]  imem_w_data,
    output logic        imem_w_en,
    output logic        cpu_reset
);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t      state_reg;
    logic [7:0]  ptr_reg;
    logic [8:0]  count_reg;
    logic [7:0]  csum_reg;
    logic        err_reg;

    logic        hit;
    logic [1:0]  reg_sel;
    logic [31:0] rd_data;

    // The !ack term makes a held strobe wait out the ack cycle before it can hit again.
    assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
    assign reg_sel = wbs_adr_i[3:2];

    wire unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:8]};

    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            2'd0: rd_data = {31'd0, state_reg == ST_RUN};
            2'd1: rd_data = {24'd0, ptr_reg};
            2'd2: rd_data = 32'd0;
            2'd3: rd_data = {7'd0, count_reg, csum_reg, 7'd0, err_reg};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg   <= ST_LOAD;
            ptr_reg     <= 8'd0;
            count_reg   <= 9'd0;
            csum_reg    <= 8'd0;
            err_reg     <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'd0;
            imem_addr   <= 8'd0;
            imem_w_data <= 8'd0;
            imem_w_en   <= 1'b0;
            cpu_reset   <= 1'b1;
        end else begin
            wbs_ack_o <= hit;
            imem_w_en <= 1'b0;
            if (hit) begin
                wbs_dat_o <= rd_data;
            end
            if (hit && wbs_we_i) begin
                case (reg_sel)
                    2'd0: begin
                        if (wbs_dat_i[0] && state_reg == ST_LOAD) begin
                            state_reg <= ST_RUN;
                            cpu_reset <= 1'b0;
                        end else if (!wbs_dat_i[0] && state_reg == ST_RUN) begin
                            state_reg <= ST_LOAD;
                            cpu_reset <= 1'b1;
                            ptr_reg   <= 8'd0;
                        end
                        // Clear takes priority over the pointer reset above.
                        if (wbs_dat_i[1]) begin
                            ptr_reg   <= 8'd0;
                            count_reg <= 9'd0;
                            csum_reg  <= 8'd0;
                        end
                    end
                    2'd1: begin
                        if (wbs_sel_i[0]) begin
                            ptr_reg <= wbs_dat_i[7:0];
                        end
                    end
                    2'd2: begin
                        if (state_reg == ST_RUN) begin
                            err_reg <= 1'b1;
                        end else if (wbs_sel_i[0]) begin
                            imem_addr   <= ptr_reg;
                            imem_w_data <= wbs_dat_i[7:0];
                            imem_w_en   <= 1'b1;
                            ptr_reg     <= ptr_reg + 8'd1;
                            csum_reg    <= csum_reg + wbs_dat_i[7:0];
                            if (count_reg != 9'd256) begin
                                count_reg <= count_reg + 9'd1;
                            end
                        end
                    end
                    2'd3: begin
                        if (wbs_dat_i[0]) begin
                            err_reg <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_prog_loader.sv
// Randomized and directed bench for wb_prog_loader, checked against a register-level
// model of the loader's programmer-visible behaviour.
module tb_wb_prog_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic [7:0]  imem_addr, imem_w_data;
    logic        imem_w_en, cpu_reset;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int m_ptr, m_count, m_csum, m_last_addr, m_last_data;
    bit m_err, m_run;

    always #5 clk = ~clk;

    wb_prog_loader #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .imem_addr  (imem_addr),
        .imem_w_data(imem_w_data),
        .imem_w_en  (imem_w_en),
        .cpu_reset  (cpu_reset)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_count = 0; m_csum = 0; m_err = 0; m_run = 0;
        m_last_addr = 0; m_last_data = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] off);
        case (off[3:2])
            2'd0:    return {31'd0, m_run};
            2'd1:    return m_ptr;
            2'd3:    return (m_count << 16) | (m_csum << 8) | m_err;
            default: return 32'd0;
        endcase
    endfunction

    // One Wishbone transfer; checks ack, read data and the side effects against the model.
    task automatic xfer(input bit w, input logic [3:0] off, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdat);
        logic [31:0] exp_rd;
        bit          exp_wen;
        int          n;
        exp_rd  = model_read(off);
        exp_wen = 0;
        if (w) begin
            case (off[3:2])
                2'd0: begin
                    if (d[0] && !m_run) m_run = 1;
                    else if (!d[0] && m_run) begin m_run = 0; m_ptr = 0; end
                    if (d[1]) begin m_ptr = 0; m_count = 0; m_csum = 0; end
                end
                2'd1: if (s[0]) m_ptr = d[7:0];
                2'd2: begin
                    if (m_run) m_err = 1;
                    else if (s[0]) begin
                        exp_wen = 1;
                        m_last_addr = m_ptr;
                        m_last_data = d[7:0];
                        m_ptr   = (m_ptr + 1) % 256;
                        m_csum  = (m_csum + d[7:0]) % 256;
                        m_count = (m_count < 256) ? m_count + 1 : 256;
                    end
                end
                2'd3: if (d[0]) m_err = 0;
                default: ;
            endcase
        end
        @(negedge clk);
        stb = 1; cyc = 1; we = w; adr = BASE | off; dat_w = d; sel = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        rdat = dat_r;
        check("ack", ack, 1'b1);
        check("w_en", imem_w_en, exp_wen);
        check("imem_addr", imem_addr, m_last_addr);
        check("imem_data", imem_w_data, m_last_data);
        check("cpu_reset", cpu_reset, !m_run);
        if (!w) check("rdata", dat_r, exp_rd);
        stb = 0; cyc = 0; we = 0;
        @(negedge clk);
        check("ack_1cyc", ack, 1'b0);
        check("w_en_1cyc", imem_w_en, 1'b0);
        $display("xfer we=%0d off=%h dat=%h sel=%h rd=%h", w, off, d, s, rdat);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        logic [31:0] r;
        xfer(1'b1, off, d, 4'hF, r);
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] r);
        xfer(1'b0, off, 32'd0, 4'hF, r);
    endtask

    initial begin
        logic [31:0] r;
        int sum;
        stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
        model_reset();

        // Reset
        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_ack", ack, 1'b0);
        check("rst_w_en", imem_w_en, 1'b0);
        check("rst_dat_o", dat_r, 32'd0);
        rst = 0;
        rd(4'hC, r);
        check("rst_status", r, 32'd0);

        // Load
        wr(4'h4, 32'h10);
        wr(4'h8, 32'hA5);
        check("load_addr0", imem_addr, 8'h10);
        wr(4'h8, 32'h5A);
        check("load_addr1", imem_addr, 8'h11);
        wr(4'h8, 32'h01);
        check("load_addr2", imem_addr, 8'h12);
        check("load_data2", imem_w_data, 8'h01);
        rd(4'hC, r);
        check("load_status", r, 32'h0003_0000);
        rd(4'h4, r);
        check("load_ptr", r, 32'h13);

        // Pointer wrap
        wr(4'h4, 32'hFF);
        wr(4'h8, 32'h07);
        check("wrap_addr0", imem_addr, 8'hFF);
        wr(4'h8, 32'h07);
        check("wrap_addr1", imem_addr, 8'h00);
        rd(4'h4, r);
        check("wrap_ptr", r, 32'h01);

        // Run lockout
        wr(4'h0, 32'h1);
        check("run_cpu_reset", cpu_reset, 1'b0);
        wr(4'h8, 32'h33);
        rd(4'hC, r);
        check("run_err", r[0], 1'b1);
        wr(4'hC, 32'h1);
        rd(4'hC, r);
        check("run_err_clr", r[0], 1'b0);
        wr(4'h0, 32'h0);
        check("load_cpu_reset", cpu_reset, 1'b1);
        rd(4'h4, r);
        check("reenter_ptr", r, 32'h0);

        // Saturation then clear
        wr(4'h0, 32'h2);
        sum = 0;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] d;
            d = $urandom;
            sum += d[7:0];
            wr(4'h8, d);
        end
        rd(4'hC, r);
        check("sat_count", r[24:16], 9'd256);
        check("sat_csum", r[15:8], sum % 256);
        wr(4'h0, 32'h2);
        rd(4'hC, r);
        check("clr_status", r, 32'h0);
        rd(4'h0, r);
        check("clr_state", r, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [3:0] off;
            logic [31:0] d;
            off = 4'($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 1) == 1) off = 4'h8;
            d = $urandom;
            if (off == 4'h0 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            xfer($urandom_range(0, 3) != 0, off | 4'($urandom_range(0, 3)), d,
                 4'($urandom_range(0, 15)), r);
        end

        // Decode miss
        @(negedge clk);
        stb = 1; cyc = 1; we = 1; adr = BASE + 32'h20; dat_w = 32'h1; sel = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("miss_ack", ack, 1'b0);
        end
        stb = 0; cyc = 0; we = 0;
        $display("xfer miss adr=%h", BASE + 32'h20);

        // Async reset during the ack cycle of a DATA write
        wr(4'h0, 32'h0);
        @(negedge clk);
        stb = 1; cyc = 1; we = 1; adr = BASE | 32'h8; dat_w = 32'h5C; sel = 4'h1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ack && n < 8);
        end
        check("arst_pre_ack", ack, 1'b1);
        check("arst_pre_w_en", imem_w_en, 1'b1);
        #1 rst = 1;
        #1;
        check("arst_ack", ack, 1'b0);
        check("arst_w_en", imem_w_en, 1'b0);
        check("arst_cpu_reset", cpu_reset, 1'b1);
        check("arst_imem_addr", imem_addr, 8'h00);
        stb = 0; cyc = 0; we = 0;
        $display("xfer async-reset during DATA ack");
        @(negedge clk);
        rst = 0;
        model_reset();
        rd(4'hC, r);
        check("arst_status", r, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
